// File: rtl/rv32i_types.sv
// Shared RV32I core types: the reorder-buffer entry record and its tag type.
package rv32i_types;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] rd_data;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate at the tail, out-of-order completion from the CDB,
// in-order retire from the head, whole-buffer discard on a branch flush.
module rob
    import rv32i_types::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  rob_entry_t       alloc_entry,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  rob_entry_t       cdb_entry,
    input  logic [TAG_W-1:0] src1_tag,
    input  logic [TAG_W-1:0] src2_tag,
    output logic             src1_ready,
    output logic             src2_ready,
    output logic [31:0]      src1_data,
    output logic [31:0]      src2_data,
    output logic             commit_en,
    output rob_entry_t       commit_data,
    output logic [TAG_W-1:0] head_tag,
    input  logic             br_flush,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    rob_entry_t       r_entry [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic       w_alloc;
    logic       w_cdb_hit;
    rob_entry_t w_new_entry;
    rob_entry_t w_cdb_merge;

    // A flush cycle must not let anything into or out of the buffer.
    assign alloc_ready = (r_count != FULL_COUNT) && !br_flush;
    assign w_alloc     = alloc_valid && alloc_ready;
    assign w_cdb_hit   = cdb_valid && r_valid[cdb_tag] && !br_flush;
    assign commit_en   = r_valid[r_head] && r_done[r_head] && !br_flush;
    assign commit_data = r_entry[r_head];
    assign head_tag    = r_head;
    assign alloc_tag   = r_tail;
    assign count       = r_count;

    assign src1_ready  = r_valid[src1_tag] && r_done[src1_tag];
    assign src2_ready  = r_valid[src2_tag] && r_done[src2_tag];
    assign src1_data   = r_entry[src1_tag].rd_data;
    assign src2_data   = r_entry[src2_tag].rd_data;

    always_comb begin
        w_new_entry           = alloc_entry;
        w_new_entry.rs1_data  = '0;
        w_new_entry.rs2_data  = '0;
        w_new_entry.rd_data   = '0;
        w_new_entry.mem_addr  = '0;
        w_new_entry.mem_rmask = '0;
        w_new_entry.mem_wmask = '0;
        w_new_entry.mem_rdata = '0;
        w_new_entry.mem_wdata = '0;
    end

    // Result broadcast keeps the dispatch-time identity of the target entry.
    always_comb begin
        w_cdb_merge         = cdb_entry;
        w_cdb_merge.inst    = r_entry[cdb_tag].inst;
        w_cdb_merge.order   = r_entry[cdb_tag].order;
        w_cdb_merge.pc      = r_entry[cdb_tag].pc;
        w_cdb_merge.rd_addr = r_entry[cdb_tag].rd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst || br_flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_cdb_hit) begin
                r_done[cdb_tag] <= 1'b1;
            end
            if (commit_en) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_alloc, commit_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the payload array is deliberately not reset; valid/done gate every use of it.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_entry[r_tail] <= w_new_entry;
        end
        if (w_cdb_hit) begin
            r_entry[cdb_tag] <= w_cdb_merge;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Table-driven bench for rob with a commit scoreboard and hand-written corner sequences.
module tb_rob;
    import rv32i_types::*;

    localparam int DEPTH = ROB_DEPTH;
    localparam int TAG_W = ROB_TAG_W;

    logic             clk;
    logic             rst;
    logic             alloc_valid;
    rob_entry_t       alloc_entry;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    rob_entry_t       cdb_entry;
    logic [TAG_W-1:0] src1_tag;
    logic [TAG_W-1:0] src2_tag;
    logic             src1_ready;
    logic             src2_ready;
    logic [31:0]      src1_data;
    logic [31:0]      src2_data;
    logic             commit_en;
    rob_entry_t       commit_data;
    logic [TAG_W-1:0] head_tag;
    logic             br_flush;
    logic [TAG_W:0]   count;

    rob #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_entry (alloc_entry),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_entry   (cdb_entry),
        .src1_tag    (src1_tag),
        .src2_tag    (src2_tag),
        .src1_ready  (src1_ready),
        .src2_ready  (src2_ready),
        .src1_data   (src1_data),
        .src2_data   (src2_data),
        .commit_en   (commit_en),
        .commit_data (commit_data),
        .head_tag    (head_tag),
        .br_flush    (br_flush),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        alloc_v;
        logic [63:0] order;
        logic        cdb_v;
        rob_tag_t    cdb_tag;
        logic [31:0] cdb_rd;
        logic        flush;
        logic        exp_commit;
        logic        exp_ready;
        rob_tag_t    exp_atag;
        logic [TAG_W:0] exp_count;
    } vec_t;

    typedef struct {
        rob_tag_t    tag;
        logic [63:0] order;
    } sb_t;

    vec_t             tbl[$];
    sb_t              sb[$];
    logic [31:0]      mdl_rd [DEPTH];
    logic [DEPTH-1:0] mdl_valid;
    rob_tag_t         mdl_tail;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input logic [63:0] order);
        return 32'h1000 + {order[29:0], 2'b00};
    endfunction

    task automatic add(input logic r, input logic av, input logic [63:0] ord,
                       input logic cv, input rob_tag_t ct, input logic [31:0] crd,
                       input logic fl, input logic ec, input logic er,
                       input rob_tag_t eat, input logic [TAG_W:0] ecnt);
        vec_t v;
        v.rst = r; v.alloc_v = av; v.order = ord; v.cdb_v = cv; v.cdb_tag = ct;
        v.cdb_rd = crd; v.flush = fl; v.exp_commit = ec; v.exp_ready = er;
        v.exp_atag = eat; v.exp_count = ecnt;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        alloc_valid = 1'b0;
        alloc_entry = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_entry   = '0;
        br_flush    = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        sb_t f;
        rst                 = v.rst;
        alloc_valid         = v.alloc_v;
        alloc_entry         = '0;
        alloc_entry.inst    = 32'h0000_0013;
        alloc_entry.order   = v.order;
        alloc_entry.pc      = pc_of(v.order);
        alloc_entry.pc_next = pc_of(v.order) + 32'd4;
        alloc_entry.rd_addr = 5'd1;
        cdb_valid           = v.cdb_v;
        cdb_tag             = v.cdb_tag;
        cdb_entry           = '0;
        cdb_entry.rd_data   = v.cdb_rd;
        br_flush            = v.flush;
        #1;
        check("commit_en", 64'(commit_en), 64'(v.exp_commit));
        check("alloc_ready", 64'(alloc_ready), 64'(v.exp_ready));
        check("alloc_tag", 64'(alloc_tag), 64'(v.exp_atag));
        if (v.exp_commit) begin
            if (sb.size() == 0) begin
                check("scoreboard_nonempty", 64'(0), 64'(1));
            end else begin
                f = sb.pop_front();
                check("commit_head_tag", 64'(head_tag), 64'(f.tag));
                check("commit_order", commit_data.order, f.order);
                check("commit_pc", 64'(commit_data.pc), 64'(pc_of(f.order)));
                check("commit_rd_data", 64'(commit_data.rd_data), 64'(mdl_rd[f.tag]));
                mdl_valid[f.tag] = 1'b0;
            end
        end
        if (v.rst || v.flush) begin
            sb.delete();
            mdl_valid = '0;
            mdl_tail  = '0;
        end else begin
            if (v.cdb_v && mdl_valid[v.cdb_tag]) mdl_rd[v.cdb_tag] = v.cdb_rd;
            if (v.alloc_v && v.exp_ready) begin
                f.tag   = mdl_tail;
                f.order = v.order;
                sb.push_back(f);
                mdl_valid[mdl_tail] = 1'b1;
                mdl_tail = mdl_tail + 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("count", 64'(count), 64'(v.exp_count));
    endtask

    task automatic run_table();
        foreach (tbl[i]) run_row(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        idle_inputs();
        rst       = 1'b1;
        src1_tag  = '0;
        src2_tag  = '0;
        mdl_valid = '0;
        mdl_tail  = '0;
        for (int i = 0; i < DEPTH; i++) mdl_rd[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_count", 64'(count), 64'(0));
        check("reset_alloc_ready", 64'(alloc_ready), 64'(1));
        check("reset_alloc_tag", 64'(alloc_tag), 64'(0));
        check("reset_head_tag", 64'(head_tag), 64'(0));
        check("reset_commit_en", 64'(commit_en), 64'(0));
        check("reset_src1_ready", 64'(src1_ready), 64'(0));

        // Three allocations, out-of-order completion, in-order retire.
        add(0,1,0, 0,0,0,     0, 0,1,0,1);
        add(0,1,1, 0,0,0,     0, 0,1,1,2);
        add(0,1,2, 0,0,0,     0, 0,1,2,3);
        add(0,0,0, 1,1,'h11,  0, 0,1,3,3);
        add(0,0,0, 1,0,'h22,  0, 0,1,3,3);
        add(0,0,0, 0,0,0,     0, 1,1,3,2);
        add(0,0,0, 0,0,0,     0, 1,1,3,1);
        add(0,0,0, 0,0,0,     0, 0,1,3,1);
        // Fill, refused allocation while committing, then tail wrap.
        add(1,0,0, 0,0,0,     0, 0,1,3,0);
        for (int i = 0; i < DEPTH; i++)
            add(0,1,64'(10 + i), 0,0,0, 0, 0,1,rob_tag_t'(i),(TAG_W+1)'(i + 1));
        add(0,1,99, 1,0,'hA0, 0, 0,0,0,8);
        add(0,1,18, 0,0,0,    0, 1,0,0,7);
        add(0,1,18, 0,0,0,    0, 0,1,0,8);
        add(0,0,0,  0,0,0,    0, 0,0,1,8);
        run_table();

        // Lookup does not forward the same-cycle CDB.
        idle_inputs();
        src1_tag          = 3'd3;
        src2_tag          = 3'd4;
        cdb_valid         = 1'b1;
        cdb_tag           = 3'd3;
        cdb_entry.rd_data = 32'h33;
        #1;
        check("lookup_no_forward", 64'(src1_ready), 64'(0));
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("lookup_ready", 64'(src1_ready), 64'(1));
        check("lookup_data", 64'(src1_data), 64'h33);
        check("lookup_not_done", 64'(src2_ready), 64'(0));
        src2_tag = 3'd0;
        #1;
        check("lookup_valid_not_done", 64'(src2_ready), 64'(0));

        // Flush with 5 entries and a done head, alloc and CDB also active.
        add(1,0,0, 0,0,0,     0, 0,0,1,0);
        for (int i = 0; i < 5; i++)
            add(0,1,64'(20 + i), 0,0,0, 0, 0,1,rob_tag_t'(i),(TAG_W+1)'(i + 1));
        add(0,0,0, 1,0,'h77,  0, 0,1,5,5);
        add(0,1,25, 1,1,'h99, 1, 0,0,5,0);
        run_table();
        idle_inputs();
        src1_tag = 3'd0;
        #1;
        check("flush_head_tag", 64'(head_tag), 64'(0));
        check("flush_tail", 64'(alloc_tag), 64'(0));
        check("flush_commit_en", 64'(commit_en), 64'(0));
        check("flush_src1_ready", 64'(src1_ready), 64'(0));
        add(0,0,0, 0,0,0, 0, 0,1,0,0);

        // CDB to an unallocated tag is ignored.
        add(0,1,30, 0,0,0,    0, 0,1,0,1);
        add(0,1,31, 0,0,0,    0, 0,1,1,2);
        add(0,0,0,  1,5,'h55, 0, 0,1,2,2);
        run_table();
        idle_inputs();
        src1_tag = 3'd5;
        #1;
        check("unalloc_src1_ready", 64'(src1_ready), 64'(0));
        check("unalloc_count", 64'(count), 64'(2));
        check("unalloc_commit_en", 64'(commit_en), 64'(0));
        check("unalloc_head_tag", 64'(head_tag), 64'(0));

        // Reset with 4 entries pending overrides flush, alloc and CDB.
        add(0,1,32, 0,0,0,    0, 0,1,2,3);
        add(0,1,33, 0,0,0,    0, 0,1,3,4);
        add(0,0,0,  1,1,'h88, 0, 0,1,4,4);
        run_table();
        idle_inputs();
        src1_tag = 3'd1;
        src2_tag = 3'd1;
        #1;
        check("pre_rst_src1_ready", 64'(src1_ready), 64'(1));
        check("pre_rst_src1_data", 64'(src1_data), 64'h88);
        add(1,1,40, 1,0,'hBB, 1, 0,0,4,0);
        run_table();
        idle_inputs();
        #1;
        check("rst_commit_en", 64'(commit_en), 64'(0));
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_alloc_tag", 64'(alloc_tag), 64'(0));
        check("rst_head_tag", 64'(head_tag), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_src1_ready", 64'(src1_ready), 64'(0));
        check("rst_src2_ready", 64'(src2_ready), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
